pb_debounce: RTL

PB_DEBOUNCE -- requirements
Module: pb_debounce

---
 rtl/pb_pkg.sv | 29 ++
 rtl/pb_debounce_ch.sv | 150 +++++++++++++++
 rtl/pb_debounce.sv | 84 ++++++++
 3 files changed

// File: rtl/pb_pkg.sv
// -----------------------------------------------------------------------------
// pb_pkg -- shared definitions for the push-button debouncer.
//   ch_state_t      : per-channel qualification state (STABLE / CHANGING)
//   NUM_PB          : number of button channels
//   *_DEF           : default values for the top-level parameters
//   level_differs() : synchronized level vs. accepted level comparison
// -----------------------------------------------------------------------------
package pb_pkg;

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } ch_state_t;

    localparam int NUM_PB         = 3;
    localparam int TICK_DIV_DEF   = 50000;
    localparam int STABLE_CNT_DEF = 4;
    localparam int LONG_CNT_DEF   = 1000;

    // Wide enough for a divider count of up to 2^20-1.
    localparam int DIV_W  = 20;
    localparam int HOLD_W = 16;

    // True when the synchronized input disagrees with the accepted level.
    function automatic logic level_differs(input logic sync_lvl, input logic clean_lvl);
        return sync_lvl ^ clean_lvl;
    endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// -----------------------------------------------------------------------------
// pb_debounce_ch -- one debounce channel: 2-flop synchronizer, STABLE/CHANGING
// qualification FSM with 4-bit tick counter, and (with PB_DEBOUNCE_LONG_EN)
// a hold counter that fires a single long-press pulse per press.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   tick         : one-cycle sample strobe from the shared divider
//   pb_raw       : raw active-low button, asynchronous to clk
//   pb_clean     : debounced active-low level, straight from a flop
//   long_press   : one-cycle pulse (only with PB_DEBOUNCE_LONG_EN)
// -----------------------------------------------------------------------------
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEF
`ifdef PB_DEBOUNCE_LONG_EN
    , parameter int LONG_CNT = LONG_CNT_DEF
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic pb_raw,
    output logic pb_clean
`ifdef PB_DEBOUNCE_LONG_EN
    , output logic long_press
`endif
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

    logic      sync1_r;
    logic      sync2_r;
    ch_state_t state_r;
    ch_state_t state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic      clean_r;
    logic      clean_s;
    logic      diff_s;

    // Two-flop synchronizer; idles at released (1).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= pb_raw;
            sync2_r <= sync1_r;
        end
    end

    // FSM state, qualification counter and accepted level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= STABLE;
            cnt_r   <= 4'd0;
            clean_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            clean_r <= clean_s;
        end
    end

    // Next-state logic; everything holds between ticks.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        clean_s = clean_r;
        diff_s  = level_differs(sync2_r, clean_r);
        if (tick) begin
            case (state_r)
                STABLE: begin
                    if (diff_s) begin
                        state_s = CHANGING;
                        cnt_s   = 4'd1;
                    end else begin
                        state_s = STABLE;
                        cnt_s   = 4'd0;
                    end
                end
                CHANGING: begin
                    if (!diff_s) begin
                        // Bounced back: restart qualification.
                        state_s = STABLE;
                        cnt_s   = 4'd0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = STABLE;
                        cnt_s   = 4'd0;
                        clean_s = ~clean_r;
                    end else begin
                        state_s = CHANGING;
                        cnt_s   = cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_s = STABLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
    end

    // Output: the accepted level flop drives the port directly.
    always_comb begin
        pb_clean = clean_r;
    end

`ifdef PB_DEBOUNCE_LONG_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);

    logic [HOLD_W-1:0] hold_r;
    logic              done_r;
    logic              long_r;

    // Hold counter; done_r marks saturation at LONG_CNT so the pulse fires
    // once per press and LONG_CNT = 2^16 still fits in 16 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r <= {HOLD_W{1'b0}};
            done_r <= 1'b0;
            long_r <= 1'b0;
        end else if (clean_r) begin
            hold_r <= {HOLD_W{1'b0}};
            done_r <= 1'b0;
            long_r <= 1'b0;
        end else if (tick && !done_r) begin
            if (hold_r == HOLD_LAST) begin
                done_r <= 1'b1;
                long_r <= 1'b1;
            end else begin
                hold_r <= hold_r + HOLD_W'(1);
                long_r <= 1'b0;
            end
        end else begin
            long_r <= 1'b0;
        end
    end

    // Output: registered long-press pulse.
    always_comb begin
        long_press = long_r;
    end
`endif

endmodule

// File: rtl/pb_debounce.sv
// -----------------------------------------------------------------------------
// pb_debounce -- three-button debouncer with a single shared sample divider.
// Optional long-press detection is compiled in with `define PB_DEBOUNCE_LONG_EN.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   pb_raw[2:0]  : raw active-low buttons (0 = pressed), asynchronous, bouncing
//   pb_clean[2:0]: debounced registered buttons, active-low
//   tick         : one-cycle sample strobe (observation only)
//   long_press   : per-button one-cycle pulse (PB_DEBOUNCE_LONG_EN only)
// -----------------------------------------------------------------------------
module pb_debounce
    import pb_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF,
    parameter int LONG_CNT   = LONG_CNT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_clean,
    output logic              tick
`ifdef PB_DEBOUNCE_LONG_EN
    , output logic [NUM_PB-1:0] long_press
`endif
);

    // Reject out-of-range configurations at elaboration.
    if (TICK_DIV < 2 || TICK_DIV > (1 << DIV_W)) begin : g_bad_tick_div
        $error("pb_debounce: TICK_DIV out of range");
    end
    if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_stable_cnt
        $error("pb_debounce: STABLE_CNT out of range");
    end
    if (LONG_CNT < 2 || LONG_CNT > (1 << HOLD_W)) begin : g_bad_long_cnt
        $error("pb_debounce: LONG_CNT out of range");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(TICK_DIV - 2);

    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_r;

    // Shared divider; tick_r is pre-decoded one count early so the strobe is
    // a flop that is high exactly while the count sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_r <= {DIV_W{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            tick_r <= (div_cnt_r == DIV_PRE);
        end
    end

    // Output: sample strobe.
    always_comb begin
        tick = tick_r;
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        pb_debounce_ch #(
            .STABLE_CNT (STABLE_CNT)
`ifdef PB_DEBOUNCE_LONG_EN
            , .LONG_CNT (LONG_CNT)
`endif
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .tick     (tick_r),
            .pb_raw   (pb_raw[i]),
            .pb_clean (pb_clean[i])
`ifdef PB_DEBOUNCE_LONG_EN
            , .long_press (long_press[i])
`endif
        );
    end

endmodule
